lc4_retire_trace_buffer: RTL

Downstream consumer of the LC4 pipeline's writeback trace port (test_* signals). On every gwe-qualified retirement it packs the committed-instruction trace into one 89-bit record and pushes it into a circular FIFO. A valid/ready drain port feeds a host readout or scoreboard. Retire, stall and drop counters support pipeline bring-up.

---
 rtl/lc4_retire_trace_buffer_if.sv | 51 +++++
 rtl/lc4_retire_trace_buffer.sv | 133 +++++++++++++
 2 files changed

// File: rtl/lc4_retire_trace_buffer_if.sv
// Trace, drain and status bundle between the LC4 writeback trace port and the
// retire trace buffer. slave = buffer side, master = pipeline/host side.
interface lc4_retire_trace_buffer_if #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic             gwe;
  logic             capture_en;
  logic             flush;
  logic [1:0]       test_stall;
  logic [15:0]      test_cur_pc;
  logic [15:0]      test_cur_insn;
  logic             test_regfile_we;
  logic [2:0]       test_regfile_wsel;
  logic [15:0]      test_regfile_data;
  logic             test_nzp_we;
  logic [2:0]       test_nzp_new_bits;
  logic             test_dmem_we;
  logic [15:0]      test_dmem_addr;
  logic [15:0]      test_dmem_data;

  logic             out_valid;
  logic             out_ready;
  logic [88:0]      out_data;

  logic [LW-1:0]    level;
  logic             overflow;
  logic [CNT_W-1:0] retire_count;
  logic [CNT_W-1:0] stall_count;
  logic [15:0]      drop_count;

  modport slave (
    input  gwe, capture_en, flush, test_stall, test_cur_pc, test_cur_insn,
           test_regfile_we, test_regfile_wsel, test_regfile_data,
           test_nzp_we, test_nzp_new_bits, test_dmem_we, test_dmem_addr,
           test_dmem_data, out_ready,
    output out_valid, out_data, level, overflow, retire_count, stall_count,
           drop_count
  );

  modport master (
    output gwe, capture_en, flush, test_stall, test_cur_pc, test_cur_insn,
           test_regfile_we, test_regfile_wsel, test_regfile_data,
           test_nzp_we, test_nzp_new_bits, test_dmem_we, test_dmem_addr,
           test_dmem_data, out_ready,
    input  out_valid, out_data, level, overflow, retire_count, stall_count,
           drop_count
  );
endinterface

// File: rtl/lc4_retire_trace_buffer.sv
// Circular FIFO of 89-bit LC4 retirement records with retire/stall/drop counters.
// Optional LC4_TRACE_NOP_FILTER_EN: NOP (insn 0000) retirements are counted as stalls, not stored.
module lc4_retire_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  lc4_retire_trace_buffer_if.slave      bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [88:0]      r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [LW-1:0]    r_level;
  logic [88:0]      r_out_data;
  logic             r_overflow;
  logic [CNT_W-1:0] r_retire_count;
  logic [CNT_W-1:0] r_stall_count;
  logic [15:0]      r_drop_count;

  logic [88:0]      w_rec;
  logic             w_event;
  logic             w_nop;
  logic             w_retire;
  logic             w_stall;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [AW-1:0]    w_rd_nxt;
  logic [LW-1:0]    w_level_after_pop;
  logic [88:0]      w_head_nxt;

  assign w_rec = {bus.test_cur_pc, bus.test_cur_insn,
                  bus.test_regfile_we, bus.test_regfile_wsel, bus.test_regfile_data,
                  bus.test_nzp_we, bus.test_nzp_new_bits,
                  bus.test_dmem_we, bus.test_dmem_addr, bus.test_dmem_data};

  assign w_event = bus.gwe & bus.capture_en;

`ifdef LC4_TRACE_NOP_FILTER_EN
  assign w_nop = (bus.test_cur_insn == 16'h0000);
`else
  assign w_nop = 1'b0;
`endif

  assign w_retire = w_event & (bus.test_stall == 2'b00) & ~w_nop;
  assign w_stall  = w_event & ((bus.test_stall != 2'b00) | w_nop);

  assign w_full  = (r_level == LW'(DEPTH));
  assign w_empty = (r_level == '0);

  // flush wins over both ports; a pop on an empty FIFO is not a pop
  assign w_pop  = ~w_empty & bus.out_ready & ~bus.flush;
  assign w_push = w_retire & ~bus.flush & (~w_full | w_pop);
  assign w_drop = w_retire & ~bus.flush & w_full & ~w_pop;

  assign w_rd_nxt          = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
  assign w_level_after_pop = w_pop ? r_level - LW'(1) : r_level;

  // The next head is the incoming record only when nothing older survives this edge
  always_comb begin
    w_head_nxt = r_mem[w_rd_nxt];
    if (w_push && (w_level_after_pop == '0)) begin
      w_head_nxt = w_rec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && w_push) begin
      r_mem[r_wr_ptr] <= w_rec;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_level    <= '0;
      r_out_data <= '0;
      r_overflow <= 1'b0;
    end else if (bus.flush) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_rd_ptr   <= w_rd_nxt;
      r_out_data <= w_head_nxt;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        r_level  <= w_level_after_pop + LW'(1);
      end else begin
        r_level  <= w_level_after_pop;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Counters survive flush; only reset clears them
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_retire_count <= '0;
      r_stall_count  <= '0;
      r_drop_count   <= '0;
    end else begin
      if (w_retire) begin
        r_retire_count <= r_retire_count + CNT_W'(1);
      end
      if (w_stall) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
      if (w_drop && (r_drop_count != 16'hFFFF)) begin
        r_drop_count <= r_drop_count + 16'd1;
      end
    end
  end

  assign bus.out_valid    = ~w_empty;
  assign bus.out_data     = r_out_data;
  assign bus.level        = r_level;
  assign bus.overflow     = r_overflow;
  assign bus.retire_count = r_retire_count;
  assign bus.stall_count  = r_stall_count;
  assign bus.drop_count   = r_drop_count;

endmodule
